axonerve_kvs_job_seq: RTL and testbench
=======================================

AXONERVE_KVS_JOB_SEQ -- requirements
Module: axonerve_kvs_job_seq

Interface
REQ-001 SHALL have parameter C_REC_BYTES, default 64, meaning bytes per record; one AXI beat carries one record; power of two.
REQ-002 SHALL have parameter C_MAX_BURST, default 16, meaning maximum records per read command; power of two, 1..256.
REQ-003 SHALL have port aclk  in  1  clock; all logic on the rising edge.
REQ-004 SHALL have port areset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port ap_start  in  1  start level from the control slave, held high until ap_done.
REQ-006 SHALL have port ap_idle  out  1  high when no job is active.
REQ-007 SHALL have port ap_done  out  1  one-cycle pulse at job completion.
REQ-008 SHALL have port data_num  in  32  record count of the job.
REQ-009 SHALL have port axi00_ptr0  in  64  byte base address of the record array.
REQ-010 SHALL have port cmd_valid  out  1  read command valid, to the AXI read master.
REQ-011 SHALL have port cmd_ready  in  1  read command accepted.
REQ-012 SHALL have port cmd_addr  out  64  byte address of the burst.
REQ-013 SHALL have port cmd_len  out  8  AXI-encoded burst length (beats-1).
REQ-014 SHALL have port rec_done  in  1  one-cycle pulse per record fully processed by the KVS engine.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-016 SHALL leave IDLE only on a rising edge of ap_start (ap_start high, previous-cycle ap_start low).
REQ-017 SHALL ignore the ap_start level while in ISSUE, WAIT or DONE.
REQ-018 SHALL, on the start edge, latch data_num and axi00_ptr0 with the low log2(C_REC_BYTES) address bits forced to zero.
REQ-019 SHALL clear the issue and completion counters on the start edge.
REQ-020 SHALL go from IDLE to DONE when the latched data_num is 0; otherwise it SHALL go to ISSUE.
REQ-021 SHALL, in ISSUE, compute beats as the minimum of: the remaining unissued records, C_MAX_BURST, and the beats to the next 4 KB boundary.
REQ-022 SHALL drive cmd_len = beats-1 in ISSUE.
REQ-023 SHALL hold cmd_valid, cmd_addr and cmd_len stable until cmd_valid and cmd_ready are both high.
REQ-024 SHALL, on each handshake, advance the address by beats*C_REC_BYTES and reduce the remaining count by beats.
REQ-025 SHALL, when the remaining count reaches 0 at a handshake, deassert cmd_valid next cycle and enter WAIT.
REQ-026 SHALL add 1 to the completion count for each rec_done pulse received in ISSUE or WAIT.
REQ-027 SHALL ignore rec_done while in IDLE or DONE, and once the completion count has reached the latched data_num.
REQ-028 SHALL go from WAIT to DONE in the cycle after the completion count equals the latched data_num.
REQ-029 SHALL, in DONE, assert ap_done for exactly one cycle and then return to IDLE.
REQ-030 SHALL drive ap_idle high in IDLE only; it SHALL go low the cycle after the start edge and return high the cycle after the ap_done pulse.
REQ-031 SHALL perform address arithmetic modulo 2^64; wrap past 2^64 is not flagged.

Reset
REQ-032 SHALL, on reset, force: state IDLE, ap_idle 1, ap_done 0, cmd_valid 0, cmd_addr 0, cmd_len 0, counters 0, start-edge register 0.
REQ-033 SHALL treat reset mid-job as an abort: no ap_done is generated.
REQ-034 SHALL require a new rising edge of ap_start after reset before starting a job; an ap_start level held high through reset SHALL NOT start a job.

Structure
REQ-035 SHALL place in shared package axonerve_kvs_pkg: the state encoding, the 4 KB boundary constant, and the cmd_len width.
REQ-036 SHALL place the burst-size computation (min of the three terms in REQ-021) in sub-module axonerve_kvs_burst_calc, purely combinational.

Verification
REQ-037 SHALL cover: data_num=40, ptr=0x1000, C_MAX_BURST=16, cmd_ready tied high -> three commands with addr 0x1000/0x1400/0x1800 and len 15/15/7.
REQ-038 SHALL cover: ptr=0x0FC0, data_num=4 -> commands 0x0FC0 len 0 and 0x1000 len 2 (4 KB split).
REQ-039 SHALL cover: data_num=0 -> no cmd_valid; ap_done pulses 2 cycles after the start edge; ap_idle low for exactly 2 cycles.
REQ-040 SHALL cover: cmd_ready held low for 5 cycles -> cmd_addr and cmd_len stable throughout; a single handshake is counted.
REQ-041 SHALL cover: data_num=3 with 5 rec_done pulses -> ap_done after the 3rd pulse; extra pulses ignored; ap_start held high afterwards does not restart the job.
REQ-042 SHALL cover: areset asserted while in WAIT -> next cycle ap_idle=1 and cmd_valid=0, and no ap_done pulse.

Source files
------------

// File: rtl/axonerve_kvs_pkg.sv
// Shared definitions for the Axonerve KVS job sequencer: state encoding,
// AXI 4 KB boundary geometry and read-command length width.
package axonerve_kvs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned BOUNDARY_BYTES = 4096;
  localparam int unsigned BOUNDARY_BITS  = 12;
  localparam int unsigned CMD_LEN_W      = 8;

endpackage

// File: rtl/axonerve_kvs_burst_calc.sv
// Burst sizing: beats = min(remaining records, C_MAX_BURST, beats left before
// the next 4 KB boundary). Purely combinational.
module axonerve_kvs_burst_calc
  import axonerve_kvs_pkg::*;
#(
  parameter int C_REC_BYTES = 64,
  parameter int C_MAX_BURST = 16
) (
  input  logic [BOUNDARY_BITS-1:0] addr_lo,
  input  logic [31:0]              remaining,
  output logic [8:0]               beats
);

  localparam int LOG2_REC = $clog2(C_REC_BYTES);
  localparam int BW       = BOUNDARY_BITS + 1;

  logic [BW-1:0] to_bnd_bytes;
  logic [BW-1:0] to_bnd_beats;
  logic [8:0]    lim_a;

  // addr_lo is record aligned, so the byte distance divides exactly into beats
  always_comb begin
    to_bnd_bytes = BW'(BOUNDARY_BYTES) - {1'b0, addr_lo};
    to_bnd_beats = to_bnd_bytes >> LOG2_REC;
    if (to_bnd_beats < BW'(C_MAX_BURST)) begin
      lim_a = 9'(to_bnd_beats);
    end else begin
      lim_a = 9'(C_MAX_BURST);
    end
    if (remaining < {23'd0, lim_a}) begin
      beats = remaining[8:0];
    end else begin
      beats = lim_a;
    end
  end

endmodule

// File: rtl/axonerve_kvs_job_seq.sv
// Job sequencer: splits a record array into AXI read bursts and waits for the
// KVS engine to report every record before pulsing ap_done.
module axonerve_kvs_job_seq
  import axonerve_kvs_pkg::*;
#(
  parameter int C_REC_BYTES = 64,
  parameter int C_MAX_BURST = 16
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        ap_start,
  output logic        ap_idle,
  output logic        ap_done,
  input  logic [31:0] data_num,
  input  logic [63:0] axi00_ptr0,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [63:0] cmd_addr,
  output logic [7:0]  cmd_len,
  input  logic        rec_done
);

  localparam int          LOG2_REC   = $clog2(C_REC_BYTES);
  localparam logic [63:0] ALIGN_MASK = 64'(C_REC_BYTES - 1);

  state_t      state;
  logic        start_low;
  logic [31:0] num;
  logic [31:0] issued;
  logic [31:0] done_cnt;

  logic        start_edge;
  logic [31:0] remaining;
  logic [8:0]  beats;
  logic [63:0] burst_bytes;

  // start_low resets to 0, so a level held high through reset is not an edge
  assign start_edge  = ap_start & start_low;
  assign remaining   = num - issued;
  assign burst_bytes = {55'd0, beats} << LOG2_REC;

  axonerve_kvs_burst_calc #(
    .C_REC_BYTES(C_REC_BYTES),
    .C_MAX_BURST(C_MAX_BURST)
  ) u_burst_calc (
    .addr_lo   (cmd_addr[BOUNDARY_BITS-1:0]),
    .remaining (remaining),
    .beats     (beats)
  );

  // Job FSM; cmd_addr doubles as the running burst address
  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= ST_IDLE;
      start_low <= 1'b0;
      ap_idle   <= 1'b1;
      ap_done   <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_addr  <= 64'd0;
      cmd_len   <= 8'd0;
      num       <= 32'd0;
      issued    <= 32'd0;
      done_cnt  <= 32'd0;
    end else begin
      start_low <= ~ap_start;
      if (rec_done && (state == ST_ISSUE || state == ST_WAIT) && done_cnt != num) begin
        done_cnt <= done_cnt + 32'd1;
      end
      case (state)
        ST_IDLE: begin
          ap_done <= 1'b0;
          if (start_edge) begin
            ap_idle  <= 1'b0;
            num      <= data_num;
            cmd_addr <= axi00_ptr0 & ~ALIGN_MASK;
            issued   <= 32'd0;
            done_cnt <= 32'd0;
            state    <= (data_num == 32'd0) ? ST_DONE : ST_ISSUE;
          end else begin
            ap_idle <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (!cmd_valid) begin
            cmd_valid <= 1'b1;
            cmd_len   <= CMD_LEN_W'(beats - 9'd1);
          end else if (cmd_ready) begin
            cmd_valid <= 1'b0;
            cmd_addr  <= cmd_addr + burst_bytes;
            issued    <= issued + {23'd0, beats};
            if (remaining == {23'd0, beats}) begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (done_cnt == num) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          ap_done <= 1'b1;
          ap_idle <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axonerve_kvs_job_seq.sv
// Self-checking bench: directed corner sequences plus a table of jobs whose
// command stream is compared against a burst-splitting reference model.
module tb_axonerve_kvs_job_seq;

  localparam int REC  = 64;
  localparam int MAXB = 16;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_idle;
  logic        ap_done;
  logic [31:0] data_num = 32'd0;
  logic [63:0] axi00_ptr0 = 64'd0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [63:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        rec_done = 1'b0;

  always #5 aclk = ~aclk;

  axonerve_kvs_job_seq #(.C_REC_BYTES(REC), .C_MAX_BURST(MAXB)) dut (
    .aclk(aclk), .areset(areset), .ap_start(ap_start), .ap_idle(ap_idle),
    .ap_done(ap_done), .data_num(data_num), .axi00_ptr0(axi00_ptr0),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .rec_done(rec_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] got_addr[$];
  int          got_len[$];
  int          hs_beats = 0;
  int          done_pulses = 0;
  int          valid_cycles = 0;
  int          stab_err = 0;
  logic        prev_wait = 1'b0;
  logic [63:0] prev_addr = 64'd0;
  logic [7:0]  prev_len = 8'd0;

  // Observe the bus mid-cycle: handshakes, done pulses and held-command stability
  always @(negedge aclk) begin
    if (areset) begin
      prev_wait = 1'b0;
    end else begin
      if (prev_wait && (!cmd_valid || cmd_addr != prev_addr || cmd_len != prev_len))
        stab_err++;
      if (cmd_valid) valid_cycles++;
      if (cmd_valid && cmd_ready) begin
        got_addr.push_back(cmd_addr);
        got_len.push_back(int'(cmd_len));
        hs_beats += int'(cmd_len) + 1;
      end
      if (ap_done) done_pulses++;
      prev_wait = cmd_valid && !cmd_ready;
      prev_addr = cmd_addr;
      prev_len  = cmd_len;
    end
  end

  typedef struct {
    int          num;
    logic [63:0] ptr;
    bit          rnd_ready;
    int          exp_cmds;
    logic [63:0] exp_addr0;
    int          exp_len_last;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    got_addr.delete();
    got_len.delete();
    hs_beats = 0;
  endtask

  task automatic start_job(input int num, input logic [63:0] ptr);
    data_num   = 32'(num);
    axi00_ptr0 = ptr;
    ap_start   = 1'b1;
  endtask

  task automatic wait_hs(input string name, input int n, input int budget);
    int c = 0;
    while (got_addr.size() < n && c < budget) begin
      tick();
      c++;
    end
    check(name, 64'(got_addr.size() >= n), 64'd1);
  endtask

  task automatic wait_done(input string name, input int d0, input int budget);
    int c = 0;
    while (done_pulses == d0 && c < budget) begin
      tick();
      c++;
    end
    check(name, 64'(done_pulses - d0), 64'd1);
  endtask

  // Reference: walk the array, each burst limited by records left, MAXB and 4 KB page
  task automatic model(input vec_t v, output logic [63:0] ea[$], output int el[$]);
    logic [63:0] a;
    int rem, b, bnd;
    ea.delete();
    el.delete();
    a   = v.ptr & ~64'(REC - 1);
    rem = v.num;
    while (rem > 0) begin
      bnd = (4096 - int'(a % 64'd4096)) / REC;
      b = rem;
      if (b > MAXB) b = MAXB;
      if (b > bnd) b = bnd;
      ea.push_back(a);
      el.push_back(b - 1);
      a = a + 64'(b * REC);
      rem -= b;
    end
  endtask

  task automatic run_job(input int idx, input vec_t v);
    logic [63:0] ea[$];
    int el[$];
    int d0, vc0, se0, sent, c, n;
    model(v, ea, el);
    clear_obs();
    d0 = done_pulses; vc0 = valid_cycles; se0 = stab_err; sent = 0; c = 0;
    start_job(v.num, v.ptr);
    while (done_pulses == d0 && c < 3000) begin
      tick();
      c++;
      cmd_ready = v.rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (sent < hs_beats && $urandom_range(0, 1) == 1) begin
        rec_done = 1'b1;
        sent++;
      end else begin
        rec_done = 1'b0;
      end
    end
    rec_done  = 1'b0;
    cmd_ready = 1'b1;
    ap_start  = 1'b0;
    repeat (3) tick();
    check($sformatf("job%0d_ncmds", idx), 64'(got_addr.size()), 64'(ea.size()));
    n = (got_addr.size() < ea.size()) ? got_addr.size() : ea.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("job%0d_addr%0d", idx, i), got_addr[i], ea[i]);
      check($sformatf("job%0d_len%0d", idx, i), 64'(got_len[i]), 64'(el[i]));
    end
    if (v.exp_cmds >= 0) begin
      check($sformatf("job%0d_tbl_ncmds", idx), 64'(got_addr.size()), 64'(v.exp_cmds));
      if (v.exp_cmds > 0 && got_addr.size() > 0) begin
        check($sformatf("job%0d_tbl_addr0", idx), got_addr[0], v.exp_addr0);
        check($sformatf("job%0d_tbl_lenlast", idx), 64'(got_len[got_len.size() - 1]),
              64'(v.exp_len_last));
      end
    end
    check($sformatf("job%0d_done_once", idx), 64'(done_pulses - d0), 64'd1);
    check($sformatf("job%0d_idle", idx), 64'(ap_idle), 64'd1);
    check($sformatf("job%0d_stable", idx), 64'(stab_err - se0), 64'd0);
    if (v.num == 0) check($sformatf("job%0d_novalid", idx), 64'(valid_cycles - vc0), 64'd0);
  endtask

  initial begin
    int d0, vc0;

    vecs[0] = '{40, 64'h1000, 1'b0, 3, 64'h1000, 7};
    vecs[1] = '{4, 64'h0FC0, 1'b0, 2, 64'h0FC0, 2};
    vecs[2] = '{0, 64'h5000, 1'b0, 0, 64'h0, 0};
    vecs[3] = '{4, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 2, 64'hFFFF_FFFF_FFFF_FF80, 1};
    vecs[4] = '{33, 64'h1234_5FFF, 1'b1, 3, 64'h1234_5FC0, 15};
    vecs[5] = '{1, 64'h40, 1'b1, 1, 64'h40, 0};
    for (int i = 6; i < 12; i++) begin
      vecs[i].num       = int'($urandom_range(1, 70));
      vecs[i].ptr       = {$urandom, $urandom};
      if (i % 2 == 1) vecs[i].ptr[11:6] = 6'h3F - 6'($urandom_range(0, 3));
      vecs[i].rnd_ready = 1'b1;
      vecs[i].exp_cmds  = -1;
      vecs[i].exp_addr0 = 64'd0;
      vecs[i].exp_len_last = 0;
    end

    repeat (3) tick();
    areset = 1'b0;
    tick();
    check("rst_idle", 64'(ap_idle), 64'd1);
    check("rst_done", 64'(ap_done), 64'd0);
    check("rst_valid", 64'(cmd_valid), 64'd0);
    check("rst_addr", cmd_addr, 64'd0);
    check("rst_len", 64'(cmd_len), 64'd0);

    // Zero-length job: idle low for two cycles, done in the second
    vc0 = valid_cycles;
    start_job(0, 64'h0);
    tick();
    check("z_idle1", 64'(ap_idle), 64'd0);
    check("z_done1", 64'(ap_done), 64'd0);
    tick();
    check("z_idle2", 64'(ap_idle), 64'd0);
    check("z_done2", 64'(ap_done), 64'd1);
    tick();
    check("z_idle3", 64'(ap_idle), 64'd1);
    check("z_done3", 64'(ap_done), 64'd0);
    check("z_novalid", 64'(valid_cycles - vc0), 64'd0);
    ap_start = 1'b0;
    repeat (2) tick();

    // Back-pressure: command held stable, one handshake counted
    clear_obs();
    d0 = done_pulses;
    cmd_ready = 1'b0;
    start_job(4, 64'h2000);
    for (int c = 0; c < 10 && !cmd_valid; c++) tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 64'(cmd_valid), 64'd1);
      check("bp_addr", cmd_addr, 64'h2000);
      check("bp_len", 64'(cmd_len), 64'd3);
      tick();
    end
    cmd_ready = 1'b1;
    repeat (4) tick();
    check("bp_one_hs", 64'(got_addr.size()), 64'd1);
    rec_done = 1'b1;
    repeat (4) tick();
    rec_done = 1'b0;
    wait_done("bp_done", d0, 20);
    ap_start = 1'b0;
    repeat (3) tick();

    // Extra rec_done pulses ignored; held ap_start does not restart
    clear_obs();
    d0 = done_pulses;
    start_job(3, 64'h3000);
    wait_hs("x_hs", 1, 20);
    for (int p = 0; p < 2; p++) begin
      rec_done = 1'b1;
      tick();
      rec_done = 1'b0;
      repeat (2) tick();
    end
    check("x_no_early_done", 64'(done_pulses - d0), 64'd0);
    rec_done = 1'b1;
    repeat (3) tick();
    rec_done = 1'b0;
    repeat (20) tick();
    check("x_done_once", 64'(done_pulses - d0), 64'd1);
    check("x_idle", 64'(ap_idle), 64'd1);
    check("x_no_restart", 64'(got_addr.size()), 64'd1);
    ap_start = 1'b0;
    repeat (2) tick();

    // Completion count saturates even when pulses arrive during ISSUE
    clear_obs();
    d0 = done_pulses;
    cmd_ready = 1'b0;
    start_job(3, 64'h3100);
    repeat (3) tick();
    rec_done = 1'b1;
    repeat (5) tick();
    rec_done = 1'b0;
    cmd_ready = 1'b1;
    wait_done("sat_done", d0, 20);
    ap_start = 1'b0;
    repeat (3) tick();

    // Reset while waiting for records aborts without ap_done
    clear_obs();
    d0 = done_pulses;
    start_job(2, 64'h4000);
    wait_hs("rw_hs", 1, 20);
    areset = 1'b1;
    tick();
    check("rw_idle", 64'(ap_idle), 64'd1);
    check("rw_valid", 64'(cmd_valid), 64'd0);
    areset = 1'b0;
    rec_done = 1'b1;
    repeat (2) tick();
    rec_done = 1'b0;
    repeat (20) tick();
    check("rw_no_done", 64'(done_pulses - d0), 64'd0);
    check("rw_no_start", 64'(got_addr.size()), 64'd1);
    check("rw_idle_hold", 64'(ap_idle), 64'd1);
    ap_start = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 12; i++) run_job(i, vecs[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
